sbldcmc_w_uart: RTL and testbench
=================================

Name: sbldcmc_w_uart

Overview:
- Quad sensored brushless-DC commutation controller, commanded over a UART receive line.
- A received byte sets enable and direction for each of 4 motors.
- Each motor's 3 hall inputs select a 6-switch gate pattern; the four patterns are concatenated on PT.
- Sits between the host UART link and four 3-phase inverter gate drivers; system clock is 50 MHz.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency (documentation only; the divider table is fixed).
- DEAD_CYCLES, 4, gate-off cycles inserted on a pattern change (only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- Rx_in  in  1  UART serial input, idles high.
- BC  in  3  baud select, as clocks per bit:
  - 001 → 217; 010 → 109; 011 → 72; 100 → 36; any other code → 434.
- HS1, HS2, HS3, HS4  in  3 each  hall sensors {H2,H1,H0} for motors 1–4.
- Mreset  out  1  one-cycle error pulse to the transmitter, requesting a resend.
- DataOut  out  8  last valid received byte.
- PT  out  24  gate drives. Motor k (1..4) occupies PT[6k-1:6k-6] = {AH,AL,BH,BL,CH,CL}.

Behaviour:
- Reset (reset=0, async): DataOut=0, PT=0, Mreset=0, command register=0, RX FSM=IDLE.
- Rx_in passes through a 2-flop synchronizer before use.
- Frame format: start(0), D0..D7 LSB first, even parity bit (D0..D7 plus parity has an even count of ones), 1 stop(1).
- Bit period N is taken from BC, latched on start-bit detection. BC changes mid-frame are ignored.
- RX FSM IDLE → START:
  - On a synchronized falling edge, wait N/2 cycles and re-sample.
  - If 1, treat as a glitch and return to IDLE with no error.
  - If 0, go to DATA.
- RX FSM DATA → PARITY → STOP: sample every N cycles, at bit centre.
- At the stop-bit sample:
  - Stop=1 and parity OK: DataOut ← byte and command ← byte, both on the same edge. Mreset stays 0.
  - Otherwise: DataOut and command unchanged; Mreset=1 for exactly one cycle.
  - Either way, return to IDLE; the next start may begin immediately.
- Command decode for motor k (0-based): enable = cmd[2k+1], dir = cmd[2k].
- Commutation table, forward (dir=0), hall → {AH,AL,BH,BL,CH,CL}:
  - 101 → 100100; 100 → 100001; 110 → 001001.
  - 010 → 011000; 011 → 010010; 001 → 000110.
- Reverse (dir=1) uses the forward entry for the bitwise-complemented hall code.
- Hall 000 or 111 (invalid), or enable=0 → pattern 000000.
- Never assert xH and xL of the same phase together.
- Hall inputs pass through 2-flop synchronizers. PT is registered.
- Latency: hall change → PT in 3 clk. Command update → PT in 1 clk.
- Motors are fully independent; a simultaneous command update and hall change resolves to the new command plus the new hall value.

Optional Feature:
- Macro SBLDC_DEADTIME_EN.
- When defined: whenever a motor's target pattern changes, that motor's 6 PT bits go to 000000 for DEAD_CYCLES clocks, then take the new pattern. A further change during the dead window restarts the window.
- When undefined: patterns apply directly, at the latency stated above.

Decomposition:
- Package sbldc_pkg holds:
  - the baud divisor constants 434/217/109/72/36;
  - the 6-entry forward commutation table;
  - the RX state enum {IDLE, START, DATA, PARITY, STOP};
  - the motor count (4) and pattern width (6).
- One sub-module, uart_rx_parity: synchronizer, baud counter, FSM, even-parity check; outputs byte, valid pulse, error pulse.
- Commutation logic is instantiated per motor in a generate loop.

Test Plan:
- Reset: hold reset=0 → PT=0, DataOut=0, Mreset=0. Release with idle Rx and HS=001 on all motors → PT stays 0.
- Motor 1 reverse, motor 2 forward: BC=100 (36 clk/bit); send 0x0B with parity=1 → DataOut=0x0B, Mreset=0.
  - HS1=001 → PT[5:0]=001001; then HS1=011 → 100001; then 010 → 100100.
  - HS2=001 → PT[11:6]=000110.
- Motor 4 forward: send 0x80 with parity=1 → PT[5:0]=000000.
  - HS4=011 → PT[23:18]=010010; then 010 → 011000; 110 → 001001; 100 → 100001; 101 → 100100.
- Parity error: send 0x0B with parity=0 → one-cycle Mreset=1; DataOut and PT unchanged. Repeat with stop=0 → same response.
- Invalid halls: with motor enabled, HS=000 and HS=111 → that motor's 6 PT bits = 000000.
- Default baud: BC=000, frame sent at 434 clk/bit → byte received correctly. The same frame sent at 36 clk/bit is not accepted.

Source files
------------

// File: rtl/sbldc_pkg.sv
// Shared constants, types and helpers for the quad BLDC commutation controller.
// Holds the baud divisor table, the forward commutation table, the RX state
// encoding and the motor/pattern dimensions.
package sbldc_pkg;

   localparam int unsigned NUM_MOTORS = 4;
   localparam int unsigned PAT_W      = 6;
   localparam int unsigned HALL_W     = 3;
   localparam int unsigned DIV_W      = 9;

   localparam logic [DIV_W-1:0] BAUD_DIV_434 = DIV_W'(434);
   localparam logic [DIV_W-1:0] BAUD_DIV_217 = DIV_W'(217);
   localparam logic [DIV_W-1:0] BAUD_DIV_109 = DIV_W'(109);
   localparam logic [DIV_W-1:0] BAUD_DIV_72  = DIV_W'(72);
   localparam logic [DIV_W-1:0] BAUD_DIV_36  = DIV_W'(36);

   // Forward table indexed by hall code {H2,H1,H0}; 000 and 111 are invalid.
   localparam logic [7:0][PAT_W-1:0] COMM_FWD = {
      6'b000000,   // 111
      6'b001001,   // 110
      6'b100100,   // 101
      6'b100001,   // 100
      6'b010010,   // 011
      6'b011000,   // 010
      6'b000110,   // 001
      6'b000000    // 000
   };

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

   function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] bc);
      case (bc)
         3'b001:  return BAUD_DIV_217;
         3'b010:  return BAUD_DIV_109;
         3'b011:  return BAUD_DIV_72;
         3'b100:  return BAUD_DIV_36;
         default: return BAUD_DIV_434;
      endcase
   endfunction

   // Reverse rotation reuses the forward entry of the complemented hall code.
   function automatic logic [PAT_W-1:0] comm_pattern(input logic en, input logic dir,
                                                     input logic [HALL_W-1:0] hall);
      logic [HALL_W-1:0] h;
      h = dir ? ~hall : hall;
      return en ? COMM_FWD[h] : '0;
   endfunction

endpackage

// File: rtl/uart_rx_parity.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Ports: clk_i, rst_ni (async active-low), rx_i (serial in, idle high),
//        bc_i (baud select, latched at start), data_o (received byte),
//        valid_o (1-cycle good-frame pulse), err_o (1-cycle bad-frame pulse).
module uart_rx_parity
   import sbldc_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   input  logic [2:0] bc_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       err_o
);

   rx_state_e        state_q, state_d;
   logic             rx_s1_q, rx_s2_q, rx_prev_q;
   logic [DIV_W-1:0] n_q, cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shreg_q;
   logic             par_q, valid_q, err_q;

   logic fall_c, half_hit_c, bit_hit_c, frame_ok_c;
   logic start_c, sample_c, shift_c, par_c, stop_c;

   assign fall_c     = rx_prev_q & ~rx_s2_q;
   assign half_hit_c = (cnt_q == DIV_W'((n_q >> 1) - DIV_W'(1)));
   assign bit_hit_c  = (cnt_q == DIV_W'(n_q - DIV_W'(1)));
   assign frame_ok_c = rx_s2_q & ~(^{shreg_q, par_q});

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fall_c) state_d = START;
         START:   if (half_hit_c) state_d = rx_s2_q ? IDLE : DATA;
         DATA:    if (bit_hit_c && (bit_idx_q == 3'd7)) state_d = PARITY;
         PARITY:  if (bit_hit_c) state_d = STOP;
         STOP:    if (bit_hit_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state datapath strobes
   always_comb begin
      start_c  = 1'b0;
      sample_c = 1'b0;
      shift_c  = 1'b0;
      par_c    = 1'b0;
      stop_c   = 1'b0;
      case (state_q)
         IDLE:   start_c  = fall_c;
         START:  sample_c = half_hit_c;
         DATA:   begin sample_c = bit_hit_c; shift_c = bit_hit_c; end
         PARITY: begin sample_c = bit_hit_c; par_c   = bit_hit_c; end
         STOP:   begin sample_c = bit_hit_c; stop_c  = bit_hit_c; end
         default: ;
      endcase
   end

   // Synchronizer, bit timing, shift register and result pulses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         n_q       <= BAUD_DIV_434;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         valid_q   <= stop_c & frame_ok_c;
         err_q     <= stop_c & ~frame_ok_c;
         if (start_c) begin
            n_q       <= baud_div(bc_i);
            cnt_q     <= '0;
            bit_idx_q <= '0;
         end else if (state_q != IDLE) begin
            cnt_q <= sample_c ? '0 : cnt_q + DIV_W'(1);
         end
         if (shift_c) begin
            shreg_q   <= {rx_s2_q, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
         end
         if (par_c) par_q <= rx_s2_q;
      end
   end

   assign data_o  = shreg_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: rtl/sbldcmc_w_uart.sv
// Quad sensored BLDC commutation controller commanded over UART.
// A good received byte becomes both DataOut and the motor command
// (bits 2k+1/2k = enable/dir of motor k). Each motor's synchronized halls
// select a 6-bit gate pattern {AH,AL,BH,BL,CH,CL} in PT[6k+5:6k].
// Ports: clk, reset (async active-low), Rx_in, BC, HS1..HS4,
//        Mreset (1-cycle bad-frame pulse), DataOut, PT.
// Optional macro SBLDC_DEADTIME_EN: blank a motor's gates for DEAD_CYCLES
// clocks whenever its target pattern changes.
module sbldcmc_w_uart
   import sbldc_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEAD_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        Rx_in,
   input  logic [2:0]                  BC,
   input  logic [HALL_W-1:0]           HS1,
   input  logic [HALL_W-1:0]           HS2,
   input  logic [HALL_W-1:0]           HS3,
   input  logic [HALL_W-1:0]           HS4,
   output logic                        Mreset,
   output logic [7:0]                  DataOut,
   output logic [NUM_MOTORS*PAT_W-1:0] PT
);

   if (CLK_HZ == 0 || DEAD_CYCLES > 255) begin : g_bad_cfg
      $error("sbldcmc_w_uart: unsupported CLK_HZ/DEAD_CYCLES");
   end

   logic [7:0]        rx_byte;
   logic              rx_valid, rx_err;
   logic [7:0]        data_q;
   logic [HALL_W-1:0] hall_raw [NUM_MOTORS];

   uart_rx_parity u_rx (
      .clk_i   (clk),
      .rst_ni  (reset),
      .rx_i    (Rx_in),
      .bc_i    (BC),
      .data_o  (rx_byte),
      .valid_o (rx_valid),
      .err_o   (rx_err)
   );

   // One register serves as DataOut and command so both update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        data_q <= '0;
      else if (rx_valid) data_q <= rx_byte;
   end

   assign DataOut = data_q;
   assign Mreset  = rx_err;

   assign hall_raw[0] = HS1;
   assign hall_raw[1] = HS2;
   assign hall_raw[2] = HS3;
   assign hall_raw[3] = HS4;

   for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_motor
      logic [HALL_W-1:0] h1_q, h2_q;
      logic [PAT_W-1:0]  pt_q;
      logic [PAT_W-1:0]  target_c;

      assign target_c = comm_pattern(data_q[2*k+1], data_q[2*k], h2_q);

      // Hall synchronizer
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            h1_q <= '0;
            h2_q <= '0;
         end else begin
            h1_q <= hall_raw[k];
            h2_q <= h1_q;
         end
      end

`ifdef SBLDC_DEADTIME_EN
      localparam int unsigned DEAD_W = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);
      logic [PAT_W-1:0]  last_q;
      logic [DEAD_W-1:0] dead_q;

      // A target change blanks the gates; the window restarts on every change.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            pt_q   <= '0;
            last_q <= '0;
            dead_q <= '0;
         end else if (target_c != last_q) begin
            last_q <= target_c;
            pt_q   <= '0;
            dead_q <= DEAD_W'(DEAD_CYCLES - 1);
         end else if (dead_q != '0) begin
            pt_q   <= '0;
            dead_q <= dead_q - DEAD_W'(1);
         end else begin
            pt_q   <= target_c;
         end
      end
`else
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) pt_q <= '0;
         else        pt_q <= target_c;
      end
`endif

      assign PT[k*PAT_W +: PAT_W] = pt_q;
   end

endmodule

// File: tb/tb_sbldcmc_w_uart.sv
// Self-checking bench for sbldcmc_w_uart: directed scenarios plus randomized
// frames and hall changes, compared with a behavioural model of the controller.
module tb_sbldcmc_w_uart;

   logic        clk;
   logic        reset;
   logic        Rx_in;
   logic [2:0]  BC;
   logic [2:0]  HS1, HS2, HS3, HS4;
   logic        Mreset;
   logic [7:0]  DataOut;
   logic [23:0] PT;

   int checks   = 0;
   int failures = 0;
   int mres_pulses = 0;
   int mres_wide   = 0;
   bit mres_prev   = 0;

   logic [7:0] m_cmd;
   logic [2:0] m_hall [4];

   sbldcmc_w_uart dut (
      .clk     (clk),
      .reset   (reset),
      .Rx_in   (Rx_in),
      .BC      (BC),
      .HS1     (HS1),
      .HS2     (HS2),
      .HS3     (HS3),
      .HS4     (HS4),
      .Mreset  (Mreset),
      .DataOut (DataOut),
      .PT      (PT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (Mreset) begin
         mres_pulses++;
         if (mres_prev) mres_wide++;
      end
      mres_prev = Mreset;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Forward commutation by hall code, straight from the controller's table.
   function automatic logic [5:0] ref_fwd(input logic [2:0] h);
      case (h)
         3'b101:  return 6'b100100;
         3'b100:  return 6'b100001;
         3'b110:  return 6'b001001;
         3'b010:  return 6'b011000;
         3'b011:  return 6'b010010;
         3'b001:  return 6'b000110;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic [23:0] ref_pt();
      logic [23:0] r;
      logic [2:0]  hh;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         hh = m_cmd[2*k] ? ~m_hall[k] : m_hall[k];
         if (m_cmd[2*k+1]) r[k*6 +: 6] = ref_fwd(hh);
      end
      return r;
   endfunction

   function automatic int bits_per(input logic [2:0] bc);
      case (bc)
         3'b001:  return 217;
         3'b010:  return 109;
         3'b011:  return 72;
         3'b100:  return 36;
         default: return 434;
      endcase
   endfunction

   task automatic apply_halls();
      HS1 = m_hall[0];
      HS2 = m_hall[1];
      HS3 = m_hall[2];
      HS4 = m_hall[3];
   endtask

   task automatic check_pt(input string tag);
      check(tag, 32'(PT), 32'(ref_pt()));
      check({tag, "_noshoot"}, 32'(PT & (PT >> 1) & 24'h555555), 32'd0);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int n, input bit scramble);
      logic [2:0] bc_save;
      bc_save = BC;
      Rx_in = 1'b0;
      repeat (n) @(negedge clk);
      if (scramble) BC = 3'($urandom);
      for (int i = 0; i < 8; i++) begin
         Rx_in = b[i];
         repeat (n) @(negedge clk);
      end
      Rx_in = (^b) ^ bad_par;
      repeat (n) @(negedge clk);
      Rx_in = ~bad_stop;
      repeat (n) @(negedge clk);
      Rx_in = 1'b1;
      BC = bc_save;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_and_check(input string tag, input logic [7:0] b, input bit bad_par,
                                  input bit bad_stop, input bit scramble);
      int p0;
      bit ok;
      p0 = mres_pulses;
      ok = !bad_par && !bad_stop;
      send_frame(b, bad_par, bad_stop, bits_per(BC), scramble);
      if (ok) m_cmd = b;
      check({tag, "_data"}, 32'(DataOut), 32'(m_cmd));
      check({tag, "_mreset"}, 32'(mres_pulses - p0), ok ? 32'd0 : 32'd1);
      check_pt({tag, "_pt"});
   endtask

   // Change one hall input and check the exact 3-clock latency to PT.
   task automatic hall_step(input int k, input logic [2:0] val, input string tag);
      logic [23:0] exp_old, exp_new;
      exp_old   = ref_pt();
      m_hall[k] = val;
      exp_new   = ref_pt();
      apply_halls();
      repeat (2) @(negedge clk);
      check({tag, "_hold"}, 32'(PT), 32'(exp_old));
      @(negedge clk);
      check({tag, "_new"}, 32'(PT), 32'(exp_new));
      check({tag, "_noshoot"}, 32'(PT & (PT >> 1) & 24'h555555), 32'd0);
   endtask

   initial begin
      int p0;
      logic [7:0] b;
      int r;

      reset = 1'b0;
      Rx_in = 1'b1;
      BC    = 3'b100;
      m_cmd = '0;
      for (int k = 0; k < 4; k++) m_hall[k] = 3'b001;
      apply_halls();
      repeat (5) @(negedge clk);
      check("rst_pt", 32'(PT), 32'd0);
      check("rst_data", 32'(DataOut), 32'd0);
      check("rst_mreset", 32'(Mreset), 32'd0);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_pt", 32'(PT), 32'd0);

      // Motor 1 reverse, motor 2 forward
      frame_and_check("cmd0b", 8'h0B, 1'b0, 1'b0, 1'b0);
      hall_step(0, 3'b011, "m1_011");
      hall_step(0, 3'b010, "m1_010");

      // Motor 4 forward only, full forward rotation
      frame_and_check("cmd80", 8'h80, 1'b0, 1'b0, 1'b0);
      hall_step(3, 3'b011, "m4_011");
      hall_step(3, 3'b010, "m4_010");
      hall_step(3, 3'b110, "m4_110");
      hall_step(3, 3'b100, "m4_100");
      hall_step(3, 3'b101, "m4_101");

      // Bad parity, then bad stop bit
      frame_and_check("badpar", 8'h0B, 1'b1, 1'b0, 1'b0);
      frame_and_check("badstop", 8'h0B, 1'b0, 1'b1, 1'b0);

      // Invalid hall codes on an enabled motor
      hall_step(3, 3'b000, "m4_inv000");
      hall_step(3, 3'b111, "m4_inv111");

      // Short low glitch on the line is dropped silently
      p0 = mres_pulses;
      Rx_in = 1'b0;
      repeat (5) @(negedge clk);
      Rx_in = 1'b1;
      repeat (60) @(negedge clk);
      check("glitch_mreset", 32'(mres_pulses - p0), 32'd0);
      check("glitch_data", 32'(DataOut), 32'(m_cmd));

      // Default baud rate, then a frame at the wrong rate
      BC = 3'b000;
      m_hall[1] = 3'b110;
      apply_halls();
      repeat (4) @(negedge clk);
      frame_and_check("baud434", 8'h4D, 1'b0, 1'b0, 1'b0);
      send_frame(8'h0B, 1'b0, 1'b0, 36, 1'b0);
      repeat (5000) @(negedge clk);
      check("wrongbaud_data", 32'(DataOut), 32'(m_cmd));
      check_pt("wrongbaud_pt");

      // Randomized frames, error injection, mid-frame BC changes and hall moves
      for (int it = 0; it < 20; it++) begin
         BC = 3'(1 + $urandom_range(0, 3));
         for (int k = 0; k < 4; k++) m_hall[k] = 3'($urandom_range(0, 7));
         apply_halls();
         repeat (4) @(negedge clk);
         b = 8'($urandom);
         r = $urandom_range(0, 7);
         frame_and_check($sformatf("rnd%0d", it), b, (r < 2), (r == 2), 1'($urandom));
         hall_step($urandom_range(0, 3), 3'($urandom_range(0, 7)), $sformatf("rndhall%0d", it));
      end

      check("mreset_width", 32'(mres_wide), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
